// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared width helpers and limits for the CIC integrator/comb stages
package cic_pkg;

    localparam int CIC_MAX_DECIM_RATE = 65535;
    localparam int CIC_MAX_DIFF_DELAY = 8;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A rate of 1 still needs a 1-bit counter so the phase register exists.
    function automatic int cnt_w(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/decim_comb_comb.sv
// rtl/decim_comb_comb.sv - comb section: delay line of DIFF_DELAY kept samples and modulo subtractor
module comb #(
    parameter int SUMMER_WIDTH = 9,
    parameter int DIFF_DELAY   = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [SUMMER_WIDTH-1:0] x,
    output logic [SUMMER_WIDTH-1:0] y
);

    logic [SUMMER_WIDTH-1:0] dly_q [DIFF_DELAY];

    // Plain modulo subtraction: CIC gain relies on the wrap, never saturate.
    assign y = x - dly_q[DIFF_DELAY-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else if (en) begin
            dly_q[0] <= x;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

endmodule

// File: rtl/decim_comb.sv
// rtl/decim_comb.sv - keeps one strobe in DECIM_RATE and applies one comb section to the kept samples
module decim_comb
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH_INP = 8,
    parameter int DATA_WIDTH_OUT = 9,
    parameter int DECIM_RATE     = 4,
    parameter int DIFF_DELAY     = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
    input  logic                      inp_samp_str,
    output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
    output logic                      out_samp_str
);

    localparam int SUMMER_WIDTH = max_w(DATA_WIDTH_INP, DATA_WIDTH_OUT);
    localparam int CW           = cnt_w(DECIM_RATE);
    localparam logic [CW-1:0] LAST_PHASE = CW'(DECIM_RATE - 1);

    logic [CW-1:0]             phase_q, phase_d;
    logic                      keep;
    logic [SUMMER_WIDTH-1:0]   x_ext, diff;
    logic [DATA_WIDTH_OUT-1:0] data_q, data_d;
    logic                      str_q;

    assign x_ext = SUMMER_WIDTH'($signed(inp_samp_data));
    assign keep  = inp_samp_str && (phase_q == LAST_PHASE);

    always_comb begin
        phase_d = phase_q;
        if (inp_samp_str) begin
            phase_d = keep ? '0 : phase_q + CW'(1);
        end
    end

    comb #(
        .SUMMER_WIDTH (SUMMER_WIDTH),
        .DIFF_DELAY   (DIFF_DELAY)
    ) u_comb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (keep),
        .x       (x_ext),
        .y       (diff)
    );

    // MSB-aligned truncation keeps the CIC gain scaling in the top bits.
    assign data_d = keep ? diff[SUMMER_WIDTH-1 -: DATA_WIDTH_OUT] : data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            data_q  <= '0;
            str_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
            str_q   <= keep;
        end
    end

    assign out_samp_data = data_q;
    assign out_samp_str  = str_q;

endmodule

// File: tb/tb_decim_comb.sv
// tb/tb_decim_comb.sv - self-checking bench for decim_comb across three parameter sets
module tb_decim_comb;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] din [NI];
    logic       str [NI];
    logic [8:0] dout_a, dout_c;
    logic [7:0] dout_b;
    logic       os_a, os_b, os_c;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decim_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(9), .DECIM_RATE(4), .DIFF_DELAY(1)) u_a (
        .clk(clk), .reset_n(reset_n), .inp_samp_data(din[0]), .inp_samp_str(str[0]),
        .out_samp_data(dout_a), .out_samp_str(os_a));
    decim_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .DECIM_RATE(1), .DIFF_DELAY(1)) u_b (
        .clk(clk), .reset_n(reset_n), .inp_samp_data(din[1]), .inp_samp_str(str[1]),
        .out_samp_data(dout_b), .out_samp_str(os_b));
    decim_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(9), .DECIM_RATE(1), .DIFF_DELAY(2)) u_c (
        .clk(clk), .reset_n(reset_n), .inp_samp_data(din[2]), .inp_samp_str(str[2]),
        .out_samp_data(dout_c), .out_samp_str(os_c));

    function automatic int rate(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int mdel(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int wout(input int i);
        return (i == 1) ? 8 : 9;
    endfunction

    // Wrap difference to the summer width, then keep the top wo bits.
    function automatic int trunc_out(input int d, input int wo);
        int sw, m;
        sw = (wo > 8) ? wo : 8;
        m  = d & ((1 << sw) - 1);
        if (m >= (1 << (sw - 1))) m = m - (1 << sw);
        return m >>> (sw - wo);
    endfunction

    function automatic int act_d(input int i);
        case (i)
            0:       return int'($signed(dout_a));
            1:       return int'($signed(dout_b));
            default: return int'($signed(dout_c));
        endcase
    endfunction
    function automatic int act_s(input int i);
        case (i)
            0:       return int'(os_a);
            1:       return int'(os_b);
            default: return int'(os_c);
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: total strobe count, list of kept samples, expected outputs.
    int n_strb [NI];
    int hist   [NI][8];
    int exp_d  [NI];
    int exp_s  [NI];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) begin
                n_strb[i] <= 0;
                exp_d[i]  <= 0;
                exp_s[i]  <= 0;
                for (int j = 0; j < 8; j++) hist[i][j] <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                exp_s[i] <= 0;
                if (str[i]) begin
                    n_strb[i] <= n_strb[i] + 1;
                    if ((n_strb[i] % rate(i)) == rate(i) - 1) begin
                        exp_d[i]   <= trunc_out(int'($signed(din[i])) - hist[i][mdel(i)-1], wout(i));
                        exp_s[i]   <= 1;
                        hist[i][0] <= int'($signed(din[i]));
                        for (int j = 1; j < 8; j++) hist[i][j] <= hist[i][j-1];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("model_str[%0d] t=%0d", i, cyc), act_s(i), exp_s[i]);
            check($sformatf("model_data[%0d] t=%0d", i, cyc), act_d(i), exp_d[i]);
        end
    end

    int qa[$], qb[$], qc[$], qa_cyc[$];
    always @(negedge clk) begin
        if (os_a) begin
            qa.push_back(int'($signed(dout_a)));
            qa_cyc.push_back(cyc);
        end
        if (os_b) qb.push_back(int'($signed(dout_b)));
        if (os_c) qc.push_back(int'($signed(dout_c)));
    end

    task automatic expect_seq(input string nm, input int got[$], input int want[$]);
        check({nm, "_count"}, got.size(), want.size());
        for (int k = 0; k < want.size() && k < got.size(); k++)
            check($sformatf("%s[%0d]", nm, k), got[k], want[k]);
    endtask

    task automatic expect_spacing(input string nm, input int c[$], input int gap);
        for (int k = 1; k < c.size(); k++)
            check($sformatf("%s[%0d]", nm, k), c[k] - c[k-1], gap);
    endtask

    task automatic strobe(input int i, input int v);
        @(negedge clk);
        for (int k = 0; k < NI; k++) str[k] = 1'b0;
        din[i] = 8'(v);
        str[i] = 1'b1;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) str[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        quiet(1);
        reset_n = 1'b0;
        quiet(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            din[k] = '0;
            str[k] = 1'b0;
        end
        quiet(3);
        check("reset_data_a", act_d(0), 0);
        check("reset_str_a", act_s(0), 0);
        reset_n = 1'b1;

        // Ramp, strobe every cycle, R=4
        for (int v = 0; v < 16; v++) strobe(0, v);
        quiet(2);
        expect_seq("ramp_a", qa, '{3, 4, 4, 4});
        expect_spacing("ramp_gap", qa_cyc, 4);

        // Wrap-around at 8-bit width
        strobe(1, 120);
        strobe(1, -120);
        quiet(2);
        expect_seq("wrap_b", qb, '{120, 16});

        // Differential delay of 2
        strobe(2, 5);
        strobe(2, 9);
        strobe(2, 14);
        strobe(2, 20);
        quiet(2);
        expect_seq("m2_c", qc, '{5, 9, 9, 11});

        // Gapped strobes every 3rd cycle
        do_reset();
        qa.delete();
        qa_cyc.delete();
        for (int v = 0; v < 16; v++) begin
            strobe(0, v);
            quiet(2);
        end
        quiet(1);
        expect_seq("gap_a", qa, '{3, 4, 4, 4});
        expect_spacing("gap_spacing", qa_cyc, 12);

        // Idle: no strobes, data holds, phase untouched
        n0 = qa.size();
        quiet(50);
        check("idle_no_strobe", qa.size(), n0);
        check("idle_hold", act_d(0), 4);
        for (int v = 16; v < 20; v++) strobe(0, v);
        quiet(2);
        check("idle_resume_count", qa.size(), n0 + 1);
        if (qa.size() > n0) check("idle_resume_data", qa[n0], 4);

        // Asynchronous reset mid-stream
        do_reset();
        qa.delete();
        for (int v = 0; v < 8; v++) strobe(0, v);
        quiet(1);
        check("pre_rst_str", act_s(0), 1);
        check("pre_rst_data", act_d(0), 4);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_data", act_d(0), 0);
        check("async_rst_str", act_s(0), 0);
        quiet(2);
        reset_n = 1'b1;
        for (int v = 0; v < 4; v++) strobe(0, v);
        quiet(2);
        expect_seq("post_rst_a", qa, '{3, 4, 3});

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/decim_comb.md
Name: decim_comb

Overview:
- Decimate-and-comb stage placed directly downstream of the CIC integrator.
- Consumes the integrator's strobed sample stream and keeps one sample in every DECIM_RATE strobes.
- Applies one comb section, y[k] = x[k] - x[k-DIFF_DELAY], to the kept samples and emits a strobed, MSB-aligned result.
- Cascaded instances form the comb half of the CIC decimator.

Parameters:
- DATA_WIDTH_INP, 8, width of the signed input sample.
- DATA_WIDTH_OUT, 9, width of the signed output sample.
- DECIM_RATE, 4, decimation factor R; legal range 1..65535.
- DIFF_DELAY, 1, comb differential delay M, counted in kept samples; legal range 1..8.

Ports:
- clk  input  1  sample clock.
- reset_n  input  1  asynchronous, active-low reset.
- inp_samp_data  input  DATA_WIDTH_INP  signed sample from the integrator; valid only when inp_samp_str=1.
- inp_samp_str  input  1  input sample strobe, one cycle per sample.
- out_samp_data  output  DATA_WIDTH_OUT  signed comb result.
- out_samp_str  output  1  output strobe, one-cycle pulse per decimated sample.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset asserts immediately, without waiting for a clock edge, and clears:
  - phase counter = 0
  - every delay-line entry = 0
  - out_samp_data = 0
  - out_samp_str = 0
- Reset release is synchronous to clk; the first strobe after release counts as phase 0.
- Width rule:
  - SUMMER_WIDTH = max(DATA_WIDTH_INP, DATA_WIDTH_OUT).
  - Input is sign-extended to SUMMER_WIDTH.
  - Subtraction is modulo 2^SUMMER_WIDTH, wrap-around with no saturation. This is required for CIC correctness.
  - out_samp_data = difference[SUMMER_WIDTH-1 -: DATA_WIDTH_OUT], i.e. MSB-aligned truncation.
- Phase counter:
  - Width is clog2(DECIM_RATE), minimum 1 bit.
  - Advances only on cycles with inp_samp_str=1; it is unaffected by cycles without a strobe.
  - A strobe at phase DECIM_RATE-1 is a "keep" event and the counter wraps to 0.
  - With DECIM_RATE=1, every strobe is a keep event.
- Keep event (cycle t):
  - diff = ext(inp_samp_data) - delay[DIFF_DELAY-1].
  - Delay line shifts: delay[0] <= ext(inp_samp_data), delay[i] <= delay[i-1].
  - At edge t+1: out_samp_data <= truncated diff and out_samp_str <= 1.
  - Latency is exactly 1 clock from the kept input strobe.
- Non-keep strobes and idle cycles:
  - Delay line unchanged.
  - out_samp_str <= 0.
  - out_samp_data holds its last value.
- Warm-up: the delay line starts at 0, so the first DIFF_DELAY outputs after reset equal the kept input itself (x - 0). No suppression.
- Back-to-back strobes on every cycle are fully supported; no stall or backpressure exists.
- out_samp_str never asserts on two consecutive cycles when DECIM_RATE > 1.
- Reset asserted mid-operation: all state is discarded immediately; there is no partial output and no pending strobe.

Decomposition:
- Package cic_pkg holds:
  - function max_w(a, b)
  - function cnt_w(r), returning clog2 with a floor of 1
  - localparam conventions shared with the integrator
- Sub-module comb:
  - Parameters SUMMER_WIDTH and DIFF_DELAY.
  - Ports clk, reset_n, en, x, y: the delay line and subtractor, updated only when en=1.
  - decim_comb owns the phase counter, sign extension, output register and truncation.

Test Plan:
1. R=4, M=1, widths 8/9; ramp 0,1,2,... with a strobe every cycle -> kept inputs 3,7,11,15 -> out_samp_data 3,4,4,4. Each out_samp_str comes 1 cycle after the strobe carrying 3/7/11/15.
2. Wrap: widths 8/8, R=1, M=1; inputs 120 then -120 -> outputs 120, then 16, since -240 mod 256 = 16.
3. Gapped strobes: R=4, M=1; ramp with a strobe every 3rd cycle -> identical output values to test 1. The output strobe is spaced 12 cycles; data holds between strobes.
4. R=1, M=2; inputs 5,9,14,20 -> outputs 5,9,9,11.
5. Reset mid-stream: R=4, M=1; assert reset_n=0 between clock edges after two kept samples -> outputs clear at once, without a clock edge. After release, ramp 0,1,2,3 -> first output 3, warm-up behaviour repeats.
6. Idle: R=4, no strobes for 50 cycles after an output of 4 -> out_samp_str stays 0, out_samp_data stays 4, and the phase counter is unchanged.
